frame_sequencer: RTL and testbench

Parametrised frame-control block for the GPU pipeline. It generates the periodic framebuffer swap/clear pulses and sequences each frame: matrix regeneration, vertex-fetch release once the framebuffer is ready, and render completion on an explicit done handshake. It sits between the control logic and the pipeline front end (matrix_gen, vertex_fetch) and the framebuffer. It adds run/single-step modes, overrun (dropped-frame) detection and per-frame statistics.

---
 rtl/frame_sequencer.sv | 150 +++++++++++++++
 tb/tb_frame_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Frame-control block: free-running swap/clear period timer plus a per-frame
// sequencer (matrix regen, buffer wait, render) with overrun detection and stats.
module frame_sequencer #(
    parameter int FRAME_PERIOD = 2_000_000,
    parameter int COUNT_WIDTH  = 16,
    parameter int TIMER_WIDTH  = $clog2(FRAME_PERIOD)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   run_in,
    input  logic                   step_in,
    input  logic                   fb_ready_in,
    input  logic                   pixel_valid_in,
    input  logic                   render_done_in,
    output logic                   swap_out,
    output logic                   clear_out,
    output logic                   matrix_start_out,
    output logic                   fetch_rst_out,
    output logic                   busy_out,
    output logic                   stats_valid_out,
    output logic                   overrun_out,
    output logic [COUNT_WIDTH-1:0] frame_count_out,
    output logic [COUNT_WIDTH-1:0] dropped_count_out,
    output logic [COUNT_WIDTH-1:0] pixel_count_out,
    output logic [TIMER_WIDTH-1:0] render_cycles_out
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT_BUF,
        RENDER,
        HOLD
    } state_t;

    localparam logic [TIMER_WIDTH-1:0] LAST_TICK = TIMER_WIDTH'(FRAME_PERIOD - 1);

    state_t                 state;
    state_t                 next_state;
    logic [TIMER_WIDTH-1:0] timer;
    logic [TIMER_WIDTH-1:0] live_cycles;
    logic [COUNT_WIDTH-1:0] live_pixels;
    logic                   pending;
    logic                   start;
    logic                   complete;
    logic                   abort;

    // Period timer runs regardless of mode; the swap pulse is registered off its last tick.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            timer     <= '0;
            swap_out  <= 1'b0;
            clear_out <= 1'b1;
        end else begin
            timer     <= (timer == LAST_TICK) ? '0 : timer + TIMER_WIDTH'(1);
            swap_out  <= (timer == LAST_TICK);
            clear_out <= (timer == LAST_TICK);
        end
    end

    assign start = swap_out && (run_in || pending);

    always_comb begin
        next_state = state;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE, HOLD: begin
                if (start) next_state = SETUP;
            end
            SETUP: begin
                next_state = WAIT_BUF;
            end
            WAIT_BUF: begin
                if (swap_out) begin
                    abort      = 1'b1;
                    next_state = start ? SETUP : HOLD;
                end else if (fb_ready_in) begin
                    next_state = RENDER;
                end
            end
            RENDER: begin
                // A done arriving on the swap cycle still counts as a completed frame.
                if (render_done_in) begin
                    complete   = 1'b1;
                    next_state = start ? SETUP : HOLD;
                end else if (swap_out) begin
                    abort      = 1'b1;
                    next_state = start ? SETUP : HOLD;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state             <= IDLE;
            pending           <= 1'b0;
            live_cycles       <= '0;
            live_pixels       <= '0;
            matrix_start_out  <= 1'b0;
            fetch_rst_out     <= 1'b1;
            busy_out          <= 1'b0;
            stats_valid_out   <= 1'b0;
            overrun_out       <= 1'b0;
            frame_count_out   <= '0;
            dropped_count_out <= '0;
            pixel_count_out   <= '0;
            render_cycles_out <= '0;
        end else begin
            state <= next_state;

            if (start) begin
                pending <= 1'b0;
            end else if (step_in && !run_in) begin
                pending <= 1'b1;
            end

            matrix_start_out <= (next_state == SETUP);
            fetch_rst_out    <= (next_state != RENDER);
            busy_out         <= (next_state == SETUP) || (next_state == WAIT_BUF) ||
                                (next_state == RENDER);
            stats_valid_out  <= complete || abort;

            if (complete || abort) begin
                pixel_count_out   <= live_pixels;
                render_cycles_out <= live_cycles;
            end
            if (complete) begin
                frame_count_out <= frame_count_out + COUNT_WIDTH'(1);
                overrun_out     <= 1'b0;
            end
            if (abort) begin
                dropped_count_out <= dropped_count_out + COUNT_WIDTH'(1);
                overrun_out       <= 1'b1;
            end

            // Clearing on SETUP too makes a frame aborted before rendering report zero stats.
            if ((next_state == SETUP) || (state == WAIT_BUF && next_state == RENDER)) begin
                live_cycles <= '0;
                live_pixels <= '0;
            end else if (state == RENDER) begin
                if (live_cycles != '1) live_cycles <= live_cycles + TIMER_WIDTH'(1);
                if (pixel_valid_in && (live_pixels != '1)) live_pixels <= live_pixels + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: directed frame scenarios plus random
// stimulus, every cycle compared against a cycle-count based reference model.
module tb_frame_sequencer;

    localparam int P  = 64;
    localparam int CW = 4;
    localparam int TW = $clog2(P);

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          run_in;
    logic          step_in;
    logic          fb_ready_in;
    logic          pixel_valid_in;
    logic          render_done_in;
    logic          swap_out;
    logic          clear_out;
    logic          matrix_start_out;
    logic          fetch_rst_out;
    logic          busy_out;
    logic          stats_valid_out;
    logic          overrun_out;
    logic [CW-1:0] frame_count_out;
    logic [CW-1:0] dropped_count_out;
    logic [CW-1:0] pixel_count_out;
    logic [TW-1:0] render_cycles_out;

    // Free-running clock; all checking happens 1 time unit after each rising edge
    always #5 clk_in = ~clk_in;

    frame_sequencer #(
        .FRAME_PERIOD(P),
        .COUNT_WIDTH (CW),
        .TIMER_WIDTH (TW)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .run_in           (run_in),
        .step_in          (step_in),
        .fb_ready_in      (fb_ready_in),
        .pixel_valid_in   (pixel_valid_in),
        .render_done_in   (render_done_in),
        .swap_out         (swap_out),
        .clear_out        (clear_out),
        .matrix_start_out (matrix_start_out),
        .fetch_rst_out    (fetch_rst_out),
        .busy_out         (busy_out),
        .stats_valid_out  (stats_valid_out),
        .overrun_out      (overrun_out),
        .frame_count_out  (frame_count_out),
        .dropped_count_out(dropped_count_out),
        .pixel_count_out  (pixel_count_out),
        .render_cycles_out(render_cycles_out)
    );

    int numChecks = 0;
    int numFails  = 0;
    int k;

    // Reference model: a frame is described by the cycle it started on and the
    // cycle its render phase began, rather than by any state encoding
    bit mActive, mRendering, mPending, mOverrun;
    int mStartCyc, mRenderStart, mPix, mFrames, mDrops, mLastPix, mLastCyc;
    bit eSwap, eClear, eMStart, eFetchRst, eBusy, eStatsValid;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numChecks++;
        if (obs !== exp) begin
            numFails++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, k, obs, exp);
        end
    endtask

    function automatic int satMin(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic checkAll;
        checkOutput("swap", swap_out, eSwap);
        checkOutput("clear", clear_out, eClear);
        checkOutput("matrix_start", matrix_start_out, eMStart);
        checkOutput("fetch_rst", fetch_rst_out, eFetchRst);
        checkOutput("busy", busy_out, eBusy);
        checkOutput("stats_valid", stats_valid_out, eStatsValid);
        checkOutput("overrun", overrun_out, mOverrun);
        checkOutput("frame_count", frame_count_out, mFrames % (1 << CW));
        checkOutput("dropped_count", dropped_count_out, mDrops % (1 << CW));
        checkOutput("pixel_count", pixel_count_out, satMin(mLastPix, (1 << CW) - 1));
        checkOutput("render_cycles", render_cycles_out, satMin(mLastCyc, (1 << TW) - 1));
    endtask

    task automatic modelReset;
        mActive = 0; mRendering = 0; mPending = 0; mOverrun = 0;
        mStartCyc = 0; mRenderStart = 0; mPix = 0;
        mFrames = 0; mDrops = 0; mLastPix = 0; mLastCyc = 0;
        eSwap = 0; eClear = 1; eMStart = 0; eFetchRst = 1; eBusy = 0; eStatsValid = 0;
        k = 0;
    endtask

    // Advance the model by one cycle using the inputs applied in cycle k,
    // producing the outputs expected during cycle k+1
    task automatic modelStep;
        bit sw, start, closed, waiting;
        sw      = (k > 0) && (k % P == 0);
        start   = sw && (run_in || mPending);
        closed  = 0;
        waiting = mActive && !mRendering && (k >= mStartCyc + 2);
        if (mRendering && render_done_in) begin
            mFrames++;
            mLastPix = mPix;
            mLastCyc = k - mRenderStart;
            mOverrun = 0;
            closed   = 1;
        end else if ((waiting || mRendering) && sw) begin
            mDrops++;
            mLastPix = mRendering ? mPix : 0;
            mLastCyc = mRendering ? k - mRenderStart : 0;
            mOverrun = 1;
            closed   = 1;
        end
        if (closed) begin
            mActive    = 0;
            mRendering = 0;
        end else if (mRendering) begin
            mPix += int'(pixel_valid_in);
        end else if (waiting && fb_ready_in) begin
            mRendering   = 1;
            mRenderStart = k + 1;
            mPix         = 0;
        end
        if (start) begin
            mActive   = 1;
            mStartCyc = k;
            mPending  = 0;
        end else if (step_in && !run_in) begin
            mPending = 1;
        end
        eSwap       = ((k + 1) % P == 0);
        eClear      = eSwap;
        eMStart     = start;
        eBusy       = mActive;
        eFetchRst   = !mRendering;
        eStatsValid = closed;
        k++;
    endtask

    // Choose inputs for the current cycle; pixels are never driven on swap or done cycles
    task automatic applyStimulus(input int mode);
        bit sw;
        sw = (k > 0) && (k % P == 0);
        case (mode)
            0: begin
                run_in = 1; step_in = 0; fb_ready_in = 1;
                render_done_in = (k == 100) || (k == 192);
                pixel_valid_in = (k >= 70) && (k < 80);
            end
            1: begin
                run_in = 0; step_in = (k == 10); fb_ready_in = 1;
                render_done_in = (k == 100);
                pixel_valid_in = (k % 3 == 0) && !sw && !render_done_in;
            end
            2: begin
                run_in = 1; step_in = 0;
                fb_ready_in = ((k >= 85) && (k < 128)) || (k >= 220);
                render_done_in = 0;
                pixel_valid_in = !sw && ($urandom_range(0, 1) == 1);
            end
            default: begin
                if ($urandom_range(0, 299) == 0) run_in = ~run_in;
                step_in        = !sw && ($urandom_range(0, 39) == 0);
                fb_ready_in    = ($urandom_range(0, 9) < 7);
                render_done_in = ($urandom_range(0, 29) == 0);
                pixel_valid_in = !sw && !render_done_in && ($urandom_range(0, 1) == 1);
            end
        endcase
    endtask

    task automatic runCycles(input int n, input int mode);
        repeat (n) begin
            applyStimulus(mode);
            modelStep();
            @(posedge clk_in);
            #1;
            checkAll();
        end
    endtask

    // Reset is held across one rising edge; the cycle after it is cycle 0
    task automatic applyReset;
        rst_in = 1;
        step_in = 0; pixel_valid_in = 0; render_done_in = 0;
        @(posedge clk_in);
        #1;
        modelReset();
        checkAll();
        rst_in = 0;
    endtask

    // Directed scenarios first, then a long random run with a reset in the middle
    initial begin
        rst_in = 1; run_in = 0; step_in = 0; fb_ready_in = 0;
        pixel_valid_in = 0; render_done_in = 0;
        modelReset();

        applyReset();
        runCycles(200, 0);
        applyReset();
        runCycles(200, 1);
        applyReset();
        runCycles(240, 2);
        applyReset();
        run_in = 1;
        runCycles(3000, 3);
        applyReset();
        runCycles(300, 3);

        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
        $finish;
    end

endmodule
